bcd_frame_packer: RTL and testbench
===================================

# bcd_frame_packer

Packs a serial stream of 4-bit BCD digits, one per accepted handshake, into a 300-digit (1200-bit) parallel frame. This is the stage directly upstream of the serial BCD-to-decimal digit stage. A full frame is held stable with `bcd_valid` high until downstream acknowledges it. The block also reports per-frame digit count and invalid-digit statistics.

## Interface
Parameters:
- `NUM_DIGITS`, default 300: digits per frame. Legal range is 1..511.
- `IDX_W`, default 9: width of the index and counters. Must hold `NUM_DIGITS`.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `in_valid`, input, 1: `in_digit` is presented.
- `in_digit`, input, 4: BCD digit.
- `in_last`, input, 1: qualified by `in_valid`; the current digit closes the frame early.
- `in_ready`, output, 1: registered; the block accepts a digit this cycle.
- `bcd`, output, 4*NUM_DIGITS: packed frame. Digit i occupies bits [4i+3:4i].
- `bcd_valid`, output, 1: registered; the frame is complete and stable.
- `bcd_ack`, input, 1: downstream has consumed the frame.
- `digit_count`, output, IDX_W: digits captured in the current frame.
- `err_count`, output, IDX_W: digits > 9 captured in the current frame.
- `err_flag`, output, 1: `err_count` != 0.

## Operation
- There are two states, FILL and FULL, held in a state register.
- **Reset values:** state=FILL, `in_ready`=0, `bcd`=0, `bcd_valid`=0, `digit_count`=0, `err_count`=0, index=0.
- `in_ready` rises on the first clock edge after reset deasserts.
- **FILL:**
  - A digit is accepted on an edge where `in_valid` & `in_ready`.
  - On accept, `in_digit` is written verbatim into slot `index`; all other slots are unchanged.
  - On accept, `index` and `digit_count` increment.
  - On accept, `err_count` increments if `in_digit` > 9. The digit is still stored verbatim; downstream handles replacement.
  - **Frame close:** the accepted digit is the last when `index == NUM_DIGITS-1` or `in_last`=1.
  - On the close edge: `in_ready`<=0, `bcd_valid`<=1, state<=FULL.
  - Unwritten slots of an early-closed frame remain 0.
  - `bcd_ack` is ignored in FILL.
- **FULL:**
  - `bcd`, `digit_count` and `err_count` are frozen.
  - `in_valid` is ignored; `in_ready` stays 0.
  - On an edge with `bcd_ack`=1: `bcd`<=0, index<=0, `digit_count`<=0, `err_count`<=0, `bcd_valid`<=0, `in_ready`<=1, state<=FILL.
- **Counters:**
  - `digit_count` saturates naturally at `NUM_DIGITS` because the frame closes there.
  - There is no wrap-around of `index` within a frame.
- `err_flag` is a combinational decode of `err_count`.
- **Reset mid-frame:** an in-progress or held frame is discarded immediately, with all outputs at their reset values asynchronously.

## Timing
- Accept to storage: one cycle. The slot is visible on `bcd` the cycle after the accepting edge.
- Close to `bcd_valid`: `bcd_valid` is high from the cycle after the closing accept.
- A full 300-digit frame with continuous `in_valid` gives `bcd_valid` high 300 cycles after the first accept edge.
- Ack to ready: `in_ready` is high the cycle after the ack edge. The minimum frame gap is one cycle.
- A `bcd_ack` that is already high when `bcd_valid` rises is honoured on the first FULL edge, so the frame is held for exactly one cycle.
- Back-pressure is upstream's responsibility. A digit offered while `in_ready`=0 is not consumed and must be held.
- `in_last` on the digit that also fills slot `NUM_DIGITS-1` closes the frame once; there is no double effect.

## Test plan
- **Full frame:** reset, then stream 300 digits with value i%10 and continuous `in_valid`.
  - Expect `bcd_valid`=1 exactly 300 cycles after the first accept.
  - Expect `bcd[3:0]`=0, `bcd[39:36]`=9, `bcd[1199:1196]`=9, `digit_count`=300, `err_flag`=0.
- **Early close:** send digits 1,2,3,4,5 with `in_last` on the 5th.
  - Expect `bcd[19:0]`=20'h54321, remaining bits 0, `digit_count`=5, `bcd_valid` high the next cycle.
- **Invalid digits:** a frame containing digits 4'hA at slot 0 and 4'hF at slot 7.
  - Expect them stored verbatim, `err_count`=2, `err_flag`=1.
  - Expect both cleared after ack.
- **Hold and back-pressure:**
  - After a full frame, keep `bcd_ack`=0 for 20 cycles while driving `in_valid`=1 with digit 3.
  - Expect `bcd` unchanged, `in_ready`=0, no accept.
  - Then pulse `bcd_ack`: the next cycle shows `bcd`=0 and `in_ready`=1, and a new frame starts at slot 0.
- **Ack in FILL:** pulse `bcd_ack` after 10 digits. Expect no change to `index`, `bcd` or `digit_count`.
- **Reset mid-frame:** assert `reset` asynchronously after 150 digits.
  - Expect all outputs to reset values immediately.
  - After release, expect `in_ready`=1 one edge later, and the next digit to land in slot 0.

Source files
------------

// File: rtl/bcd_frame_packer_if.sv
// Handshake and frame bus between the digit source, the frame packer and the
// downstream BCD-to-decimal stage. The master side is whoever feeds digits
// and acknowledges frames; the slave side is the packer itself.
interface bcd_frame_packer_if #(
    parameter int NUM_DIGITS = 300,
    parameter int IDX_W      = 9
);
    logic                    in_valid;
    logic [3:0]              in_digit;
    logic                    in_last;
    logic                    in_ready;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic                    bcd_valid;
    logic                    bcd_ack;
    logic [IDX_W-1:0]        digit_count;
    logic [IDX_W-1:0]        err_count;
    logic                    err_flag;

    modport master (
        output in_valid,
        output in_digit,
        output in_last,
        output bcd_ack,
        input  in_ready,
        input  bcd,
        input  bcd_valid,
        input  digit_count,
        input  err_count,
        input  err_flag
    );

    modport slave (
        input  in_valid,
        input  in_digit,
        input  in_last,
        input  bcd_ack,
        output in_ready,
        output bcd,
        output bcd_valid,
        output digit_count,
        output err_count,
        output err_flag
    );
endinterface

// File: rtl/bcd_frame_packer.sv
// Collects a serial stream of 4-bit BCD digits into one wide parallel frame.
// The frame fills slot by slot from slot 0; it closes either when the last
// slot is written or when the source flags the digit as the last one. A closed
// frame is held stable with bcd_valid high until downstream acknowledges it,
// after which the frame storage and statistics are cleared for the next one.
// Digits above 9 are stored untouched and only counted; replacing them is the
// downstream stage's job.
module bcd_frame_packer #(
    parameter int NUM_DIGITS = 300,
    parameter int IDX_W      = 9
) (
    input logic              clk,
    input logic              reset,
    bcd_frame_packer_if.slave bus
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    state_t                  r_state;
    state_t                  w_nextState;
    logic                    r_inReady;
    logic                    w_nextReady;
    logic                    r_bcdValid;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [IDX_W-1:0]        r_index;
    logic [IDX_W-1:0]        r_digitCount;
    logic [IDX_W-1:0]        r_errCount;
    logic                    w_accept;
    logic                    w_close;
    logic                    w_release;
    logic                    w_badDigit;

    assign w_badDigit = (bus.in_digit > 4'd9);

    // Decide what this edge does: accept a digit, close the frame, or release
    // a held frame after the downstream ack. The ack only matters while full,
    // and in_valid only matters while filling.
    always_comb begin
        w_nextState = r_state;
        w_nextReady = r_inReady;
        w_accept    = 1'b0;
        w_close     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_FILL: begin
                w_accept = bus.in_valid && r_inReady;
                w_close  = w_accept && ((r_index == LAST_IDX) || bus.in_last);
                if (w_close) begin
                    w_nextState = S_FULL;
                    w_nextReady = 1'b0;
                end else begin
                    w_nextReady = 1'b1;
                end
            end
            S_FULL: begin
                w_nextReady = 1'b0;
                if (bus.bcd_ack) begin
                    w_release   = 1'b1;
                    w_nextState = S_FILL;
                    w_nextReady = 1'b1;
                end
            end
            default: begin
                w_nextState = S_FILL;
                w_nextReady = 1'b0;
            end
        endcase
    end

    // State and handshake flags; bcd_valid simply mirrors being in FULL so it
    // rises the cycle after the closing accept and drops the cycle after ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FILL;
            r_inReady  <= 1'b0;
            r_bcdValid <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_inReady  <= w_nextReady;
            r_bcdValid <= (w_nextState == S_FULL);
        end
    end

    // Write pointer and per-frame statistics; the frame closes at the last
    // slot so the pointer never needs to wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index      <= '0;
            r_digitCount <= '0;
            r_errCount   <= '0;
        end else if (w_release) begin
            r_index      <= '0;
            r_digitCount <= '0;
            r_errCount   <= '0;
        end else if (w_accept) begin
            r_index      <= r_index + ONE;
            r_digitCount <= r_digitCount + ONE;
            if (w_badDigit) begin
                r_errCount <= r_errCount + ONE;
            end
        end
    end

    // Frame storage: the accepted digit goes verbatim into the slot selected
    // by the write pointer, everything else keeps its value, and the whole
    // frame returns to zero once downstream has consumed it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcd <= '0;
        end else if (w_release) begin
            r_bcd <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (r_index == IDX_W'(i)) begin
                    r_bcd[4*i +: 4] <= bus.in_digit;
                end
            end
        end
    end

    assign bus.in_ready    = r_inReady;
    assign bus.bcd_valid   = r_bcdValid;
    assign bus.bcd         = r_bcd;
    assign bus.digit_count = r_digitCount;
    assign bus.err_count   = r_errCount;
    assign bus.err_flag    = (r_errCount != '0);

endmodule

// File: tb/tb_bcd_frame_packer.sv
// Self-checking bench for the BCD frame packer. A queue-based model of the
// frame under construction is advanced on every clock edge; a single checker
// compares every DUT output against it on each falling edge. Directed
// scenarios pin the model with hand-computed literal values, then a long
// randomized phase exercises arbitrary handshakes, early closes and acks.
module tb_bcd_frame_packer;

    localparam int N     = 300;
    localparam int IDX_W = 9;

    logic clk = 1'b0;
    logic reset = 1'b0;
    bit   checkEn = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Model: digits captured so far in order, whether the frame is held, and
    // whether the packer should currently be ready.
    logic [3:0] mQ[$];
    bit         mHeld;
    bit         mReady;
    bit         mAccepted;

    bcd_frame_packer_if #(.NUM_DIGITS(N), .IDX_W(IDX_W)) bus ();

    bcd_frame_packer #(.NUM_DIGITS(N), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkFrame(input logic [4*N-1:0] act, input logic [4*N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL bcd: got %h, expected %h", act, exp);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        mHeld     = 1'b0;
        mReady    = 1'b0;
        mAccepted = 1'b0;
    endtask

    // One clock edge of the packer's behaviour, described in terms of the
    // digit list rather than slots and pointers.
    task automatic modelStep(input bit iv, input logic [3:0] d, input bit last, input bit ack);
        mAccepted = 1'b0;
        if (mHeld) begin
            if (ack) begin
                mQ.delete();
                mHeld  = 1'b0;
                mReady = 1'b1;
            end
        end else if (iv && mReady) begin
            mQ.push_back(d);
            mAccepted = 1'b1;
            if (last || mQ.size() == N) begin
                mHeld  = 1'b1;
                mReady = 1'b0;
            end
        end else begin
            mReady = 1'b1;
        end
    endtask

    function automatic logic [4*N-1:0] modelBcd();
        logic [4*N-1:0] r;
        r = '0;
        foreach (mQ[i]) r[4*i +: 4] = mQ[i];
        return r;
    endfunction

    function automatic int modelErr();
        int n;
        n = 0;
        foreach (mQ[i]) if (mQ[i] > 4'd9) n++;
        return n;
    endfunction

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic applyStimulus(input bit iv, input logic [3:0] d, input bit last, input bit ack);
        bus.in_valid = iv;
        bus.in_digit = d;
        bus.in_last  = last;
        bus.bcd_ack  = ack;
        @(posedge clk);
        modelStep(iv, d, last, ack);
        #1;
    endtask

    // The one compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("in_ready", 64'(bus.in_ready), 64'(mReady));
            checkOutput("bcd_valid", 64'(bus.bcd_valid), 64'(mHeld));
            checkOutput("digit_count", 64'(bus.digit_count), 64'(mQ.size()));
            checkOutput("err_count", 64'(bus.err_count), 64'(modelErr()));
            checkOutput("err_flag", 64'(bus.err_flag), 64'(modelErr() != 0));
            checkFrame(bus.bcd, modelBcd());
        end
    end

    // Hard bound on total simulated time.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] cur;
        logic [3:0] badFrame [8];
        bit         lastBit;
        bit         noLast;
        bit         iv;
        bit         ack;

        bus.in_valid = 1'b0;
        bus.in_digit = 4'd0;
        bus.in_last  = 1'b0;
        bus.bcd_ack  = 1'b0;
        modelReset();
        #1;
        reset = 1'b1;
        #1;
        checkEn = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("rst_bcd_valid", 64'(bus.bcd_valid), 64'd0);
        checkOutput("rst_bcd_zero", 64'(|bus.bcd), 64'd0);
        checkOutput("rst_digit_count", 64'(bus.digit_count), 64'd0);
        checkOutput("rst_err_count", 64'(bus.err_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("ready_after_reset", 64'(bus.in_ready), 64'd1);

        $display("[TB] full frame");
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b1, 4'(i % 10), 1'b0, 1'b0);
            if (i == N - 2) checkOutput("valid_not_early", 64'(bus.bcd_valid), 64'd0);
        end
        checkOutput("full_valid", 64'(bus.bcd_valid), 64'd1);
        checkOutput("full_slot0", 64'(bus.bcd[3:0]), 64'h0);
        checkOutput("full_slot9", 64'(bus.bcd[39:36]), 64'h9);
        checkOutput("full_slot299", 64'(bus.bcd[1199:1196]), 64'h9);
        checkOutput("full_count", 64'(bus.digit_count), 64'd300);
        checkOutput("full_err_flag", 64'(bus.err_flag), 64'd0);

        $display("[TB] hold and back-pressure");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
            checkOutput("hold_in_ready", 64'(bus.in_ready), 64'd0);
            checkOutput("hold_count", 64'(bus.digit_count), 64'd300);
            checkOutput("hold_slot1", 64'(bus.bcd[7:4]), 64'h1);
        end
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b1);
        checkOutput("ack_bcd_zero", 64'(|bus.bcd), 64'd0);
        checkOutput("ack_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("ack_valid_low", 64'(bus.bcd_valid), 64'd0);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
        checkOutput("restart_slot0", 64'(bus.bcd[3:0]), 64'h3);
        checkOutput("restart_count", 64'(bus.digit_count), 64'd1);

        $display("[TB] ack while filling");
        for (int i = 1; i < 10; i++) applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("fill_ack_count", 64'(bus.digit_count), 64'd10);
        checkOutput("fill_ack_slot9", 64'(bus.bcd[39:36]), 64'h5);
        applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
        checkOutput("fill_ack_slot10", 64'(bus.bcd[43:40]), 64'h6);
        applyStimulus(1'b1, 4'd7, 1'b1, 1'b0);
        checkOutput("fill_ack_close", 64'(bus.bcd_valid), 64'd1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);

        $display("[TB] early close");
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 4'(i), (i == 5), 1'b0);
        checkOutput("early_low", 64'(bus.bcd[19:0]), 64'h54321);
        checkOutput("early_rest_zero", 64'(|bus.bcd[1199:20]), 64'd0);
        checkOutput("early_count", 64'(bus.digit_count), 64'd5);
        checkOutput("early_valid", 64'(bus.bcd_valid), 64'd1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);

        $display("[TB] invalid digits");
        badFrame = '{4'hA, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'hF};
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, badFrame[i], (i == 7), 1'b0);
        checkOutput("bad_slot0", 64'(bus.bcd[3:0]), 64'hA);
        checkOutput("bad_slot7", 64'(bus.bcd[31:28]), 64'hF);
        checkOutput("bad_err_count", 64'(bus.err_count), 64'd2);
        checkOutput("bad_err_flag", 64'(bus.err_flag), 64'd1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("bad_cleared_count", 64'(bus.err_count), 64'd0);
        checkOutput("bad_cleared_flag", 64'(bus.err_flag), 64'd0);

        $display("[TB] ack already high at close");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i + 2), (i == 3), 1'b1);
        checkOutput("preack_count", 64'(bus.digit_count), 64'd4);
        checkOutput("preack_valid", 64'(bus.bcd_valid), 64'd1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("preack_one_cycle", 64'(bus.bcd_valid), 64'd0);
        checkOutput("preack_ready", 64'(bus.in_ready), 64'd1);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 150; i++) applyStimulus(1'b1, 4'($urandom_range(9)), 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("mid_rst_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("mid_rst_valid", 64'(bus.bcd_valid), 64'd0);
        checkOutput("mid_rst_bcd", 64'(|bus.bcd), 64'd0);
        checkOutput("mid_rst_count", 64'(bus.digit_count), 64'd0);
        checkOutput("mid_rst_err", 64'(bus.err_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
        checkOutput("mid_rel_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("mid_rel_count", 64'(bus.digit_count), 64'd0);
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
        checkOutput("mid_rel_slot0", 64'(bus.bcd[3:0]), 64'h8);
        checkOutput("mid_rel_count1", 64'(bus.digit_count), 64'd1);
        applyStimulus(1'b1, 4'd9, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);

        $display("[TB] randomized traffic");
        cur     = 4'($urandom_range(15));
        noLast  = 1'b0;
        lastBit = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            iv  = ($urandom_range(3) != 0);
            ack = mHeld ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
            applyStimulus(iv, cur, lastBit, ack);
            if (mAccepted) begin
                if (mHeld) noLast = ($urandom_range(1) == 1);
                cur     = 4'($urandom_range(15));
                lastBit = !noLast && ($urandom_range(39) == 0);
            end
        end

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
